rf_write_arbiter: RTL
=====================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-002 SHALL take parameters: AW, default 5, register-address width; DW, default 32, data width.
REQ-003 SHALL have ports, listed as name, direction, width, meaning:
  clk  in  1  rising-edge clock
  rst  in  1  async active-high reset
  a_valid  in  1  requester A (ALU writeback) offers a write
  a_ready  out  1  A entry accepted this edge when valid
  a_reg  in  AW  A destination register
  a_data  in  DW  A write data
  b_valid  in  1  requester B (load writeback) offers a write
  b_ready  out  1  B entry accepted this edge when valid
  b_reg  in  AW  B destination register
  b_data  in  DW  B write data
  RegWrite  out  1  register-file write enable, registered
  write_reg  out  AW  register-file write address, registered
  write_data  out  DW  register-file write data, registered
  q_reg1, q_reg2  in  AW  hazard query addresses
  q_pend1, q_pend2  out  1  write pending to queried register

Function
REQ-004 SHALL hold one single-entry buffer per requester (full flag, reg, data, age bit).
REQ-005 SHALL accept x_valid && x_ready at a rising edge into buffer x.
REQ-006 SHALL drive x_ready = !full_x || grant_x, combinationally, with no dependence on x_valid.
REQ-007 SHALL compute the grant combinationally from the full flags, the registers, age and the round-robin pointer only.
REQ-008 Grant, one full: SHALL grant that buffer.
REQ-009 Grant, both full, different registers: SHALL grant the requester not granted last (pointer).
REQ-010 Grant, both full, same register: SHALL grant the older entry; if both arrived on the same edge, SHALL grant A.
REQ-011 SHALL toggle the pointer only on a grant made with both buffers full.
REQ-012 On a grant edge: SHALL clear the granted buffer, unless it is refilled on the same edge, and SHALL register write_reg/write_data from it.
REQ-013 On a grant edge: SHALL set RegWrite = 1 unless the granted reg == 0; a reg-0 entry consumes the slot with RegWrite = 0.
REQ-014 With no grant, RegWrite SHALL be 0 next cycle; write_reg and write_data SHALL hold their values.
REQ-015 Latency: SHALL accept at edge N, with RegWrite high during cycle N+1..N+2 when uncontended; the register file writes at edge N+2.
REQ-016 Throughput: SHALL sustain one write per cycle, and one requester SHALL stream back-to-back.
REQ-017 Starvation bound: with both full continuously, each requester SHALL be granted within 2 cycles.
REQ-018 q_pendK SHALL be 1 iff q_regK != 0 and it matches a full buffer reg or (RegWrite && write_reg).
REQ-019 q_pendK SHALL be combinational.
REQ-020 SHALL set the age bit of an entry when it is accepted while the other buffer is full and not granted.

Reset
REQ-021 While rst = 1, the block SHALL force: buffers empty; RegWrite = 0; write_reg = 0; write_data = 0; pointer preferring A; age bits 0.
REQ-022 Consequently a_ready = b_ready = 1 and q_pend = 0 during and after reset.
REQ-023 Reset mid-operation SHALL drop all buffered and in-flight writes with no RegWrite pulse.
REQ-024 SHALL apply reset asynchronously; release is synchronous to clk by the environment.

Structure
REQ-025 Shared package rf_pkg SHALL hold AW, DW, REG_ZERO and the write-entry struct (reg, data).
REQ-026 Sub-module rf_wb_slot SHALL implement one buffer (load, clear, full, entry) and be instantiated twice.
REQ-027 All outputs except ready and q_pend SHALL be flopped.

Verification
REQ-028 A-only write: a_valid with a_reg=5, a_data=0x1234 at edge 1 -> RegWrite=1, write_reg=5, write_data=0x1234 after edge 2; a_ready stays 1.
REQ-029 Simultaneous A(reg 3, 0xA) and B(reg 4, 0xB) held valid for 4 cycles -> writes alternate A,B,A,B; neither ready low for more than 1 cycle.
REQ-030 Same-register ordering: B(reg 7, 0x1) accepted one edge before A(reg 7, 0x2) -> B written first; final write_data for reg 7 = 0x2.
REQ-031 Reg-0 write: a_reg=0, a_data=0xFFFF -> RegWrite stays 0 and q_pend for q_reg1=0 stays 0.
REQ-032 Hazard query: q_reg1=9 with B(reg 9) buffered -> q_pend1=1 until the cycle after RegWrite drops.
REQ-033 Reset mid-operation: rst pulsed with both buffers full -> RegWrite=0 immediately, ready=1, and no write occurs after release.

Source files
------------

// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file write arbiter.
//   AW       : default register-address width
//   DW       : default write-data width
//   REG_ZERO : hard-wired zero register; writes to it are swallowed
//   wr_entry_t : one buffered write (destination register + data)
// ---------------------------------------------------------------------------
package rf_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_entry_t;

endpackage : rf_pkg

// File: rtl/rf_wb_slot.sv
// ---------------------------------------------------------------------------
// rf_wb_slot
// Single-entry writeback buffer for one requester.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   load         : capture in_reg/in_data this edge (wins over clear)
//   clear        : entry was granted and drains this edge
//   age_in       : age bit stored with a newly loaded entry (1 = younger
//                  than the entry waiting in the other slot)
//   age_clr      : the other slot just loaded a younger entry, so this
//                  entry is now the older one
//   in_reg/data  : entry being loaded
//   full         : slot holds a valid entry
//   entry_reg/data : stored entry
//   age          : stored age bit
// ---------------------------------------------------------------------------
module rf_wb_slot #(
  parameter int AW = rf_pkg::AW,
  parameter int DW = rf_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic          age_in,
  input  logic          age_clr,
  input  logic [AW-1:0] in_reg,
  input  logic [DW-1:0] in_data,
  output logic          full,
  output logic [AW-1:0] entry_reg,
  output logic [DW-1:0] entry_data,
  output logic          age
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  // NOTE: the stored entry is reset along with the full flag; it is only a
  // few flops and keeps the hazard compare free of X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full       <= 1'b0;
      age        <= 1'b0;
      entry_reg  <= '0;
      entry_data <= '0;
    end else if (load) begin
      // A refill on the grant edge keeps the slot full.
      full       <= 1'b1;
      age        <= age_in;
      entry_reg  <= in_reg;
      entry_data <= in_data;
    end else begin
      if (clear) begin
        full <= 1'b0;
        age  <= 1'b0;
      end
      if (age_clr) begin
        age <= 1'b0;
      end
    end
  end

endmodule : rf_wb_slot

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
// Merges two writeback streams (A = ALU, B = load) into the single register
// file write port. Each requester owns a one-entry buffer; one buffered
// entry is granted per cycle and registered onto the write port.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   a_valid/a_ready/a_reg/a_data : requester A handshake and entry
//   b_valid/b_ready/b_reg/b_data : requester B handshake and entry
//   RegWrite/write_reg/write_data : registered register-file write port
//   q_reg1/q_reg2            : hazard query addresses
//   q_pend1/q_pend2          : combinational "write still pending" flags
// Arbitration:
//   one slot full          -> grant it
//   both full, diff regs   -> grant the side not granted last (pref_b)
//   both full, same reg    -> grant the older entry; same-edge arrivals go A
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int AW = rf_pkg::AW,
  parameter int DW = rf_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_reg,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_reg,
  input  logic [DW-1:0] b_data,
  output logic          RegWrite,
  output logic [AW-1:0] write_reg,
  output logic [DW-1:0] write_data,
  input  logic [AW-1:0] q_reg1,
  input  logic [AW-1:0] q_reg2,
  output logic          q_pend1,
  output logic          q_pend2
);

  logic          a_full, b_full;
  logic          a_age, b_age;
  logic [AW-1:0] a_ereg, b_ereg;
  logic [DW-1:0] a_edata, b_edata;
  logic          grant_a, grant_b;
  logic          load_a, load_b;
  logic          a_age_in, b_age_in;
  logic          pref_b;      // 0: prefer A on a different-register tie
  logic [AW-1:0] sel_reg;
  logic [DW-1:0] sel_data;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned (no latch).
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_full && b_full) begin
      if (a_ereg == b_ereg) begin
        // At most one age bit is set; a set bit marks the younger entry.
        grant_a = !a_age;
        grant_b =  a_age;
      end else begin
        grant_a = !pref_b;
        grant_b =  pref_b;
      end
    end else begin
      grant_a = a_full;
      grant_b = b_full;
    end
  end

  // Ready never looks at valid, so the producer may use it to decide valid.
  assign a_ready = !a_full || grant_a;
  assign b_ready = !b_full || grant_b;
  assign load_a  = a_valid && a_ready;
  assign load_b  = b_valid && b_ready;

  // A new entry is younger only if the other side is still waiting behind it.
  assign a_age_in = b_full && !grant_b;
  assign b_age_in = a_full && !grant_a;

  rf_wb_slot #(.AW(AW), .DW(DW)) u_slot_a (
    .clk        (clk),
    .rst        (rst),
    .load       (load_a),
    .clear      (grant_a),
    .age_in     (a_age_in),
    .age_clr    (load_b && b_age_in),
    .in_reg     (a_reg),
    .in_data    (a_data),
    .full       (a_full),
    .entry_reg  (a_ereg),
    .entry_data (a_edata),
    .age        (a_age)
  );

  rf_wb_slot #(.AW(AW), .DW(DW)) u_slot_b (
    .clk        (clk),
    .rst        (rst),
    .load       (load_b),
    .clear      (grant_b),
    .age_in     (b_age_in),
    .age_clr    (load_a && a_age_in),
    .in_reg     (b_reg),
    .in_data    (b_data),
    .full       (b_full),
    .entry_reg  (b_ereg),
    .entry_data (b_edata),
    .age        (b_age)
  );

  assign sel_reg  = grant_b ? b_ereg  : a_ereg;
  assign sel_data = grant_b ? b_edata : a_edata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      pref_b     <= 1'b0;
    end else begin
      if (grant_a || grant_b) begin
        // A register-0 entry still uses the slot but never writes.
        RegWrite   <= (sel_reg != '0);
        write_reg  <= sel_reg;
        write_data <= sel_data;
      end else begin
        RegWrite <= 1'b0;
      end
      // Pointer names the side not granted last; only contended grants move
      // it, and for the common alternating case this is a plain toggle.
      if (a_full && b_full) begin
        pref_b <= grant_a;
      end
    end
  end

  // Pending: waiting in either buffer or being written this cycle.
  assign q_pend1 = (q_reg1 != '0) &&
                   ((a_full && (a_ereg == q_reg1)) ||
                    (b_full && (b_ereg == q_reg1)) ||
                    (RegWrite && (write_reg == q_reg1)));
  assign q_pend2 = (q_reg2 != '0) &&
                   ((a_full && (a_ereg == q_reg2)) ||
                    (b_full && (b_ereg == q_reg2)) ||
                    (RegWrite && (write_reg == q_reg2)));

endmodule : rf_write_arbiter
